// File: rtl/wdt_pkg.sv
// Shared watchdog definitions: FSM state encoding and default counter width.
package wdt_pkg;
    localparam int unsigned WDT_CNT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RECOVER = 2'd2,
        FAULT   = 2'd3
    } wdt_state_t;
endpackage

// File: rtl/wdt_interval_timer.sv
// Loadable up/down counter with a terminal-value flag.
module wdt_interval_timer #(
    parameter int unsigned W    = 5,
    parameter bit          DOWN = 1'b0,
    parameter int unsigned LOAD = 0,
    parameter int unsigned TERM = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic step,
    output logic term
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (load) cnt <= W'(LOAD);
        else if (step) cnt <= DOWN ? cnt - 1'b1 : cnt + 1'b1;
    end

    assign term = (cnt == W'(TERM));
endmodule

// File: rtl/wdt_service_ctrl.sv
// Watchdog service supervisor: kicks on proven liveness, recovers on timeout,
// escalates to a sticky fault after repeated timeouts.
module wdt_service_ctrl
    import wdt_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = WDT_CNT_WIDTH,
    parameter int unsigned KICK_INTERVAL = 8,
    parameter int unsigned HOLDOFF       = 4,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       alive,
    input  logic       timeout,
    output logic       service,
    output logic       wd_rst_req,
    output logic       fault,
    output logic [1:0] state,
    output logic [1:0] retry_cnt
);
    localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    wdt_state_t state_q, state_d;
    logic       svc_d, wdr_d, fault_d, seen_q, seen_d;
    logic [1:0] retry_d;
    logic       k_load, k_step, k_term, h_load, h_step, h_term;

    wdt_interval_timer #(.W(CNT_WIDTH), .DOWN(1'b0), .LOAD(0), .TERM(KICK_INTERVAL - 1)) u_kick (
        .clk(clk), .rst_n(rst_n), .load(k_load), .step(k_step), .term(k_term)
    );

    wdt_interval_timer #(.W(HW), .DOWN(1'b1), .LOAD(HOLDOFF - 1), .TERM(0)) u_holdoff (
        .clk(clk), .rst_n(rst_n), .load(h_load), .step(h_step), .term(h_term)
    );

    always_comb begin
        state_d = state_q;
        svc_d   = 1'b0;
        wdr_d   = 1'b0;
        fault_d = fault;
        retry_d = retry_cnt;
        seen_d  = seen_q;
        k_load  = 1'b0;
        k_step  = 1'b0;
        h_load  = 1'b0;
        h_step  = 1'b0;
        case (state_q)
            IDLE: begin
                k_load = 1'b1;
                seen_d = 1'b0;
                if (en) begin
                    state_d = ARMED;
                    svc_d   = 1'b1;
                end
            end
            ARMED: begin
                if (!en) begin
                    state_d = IDLE;
                    k_load  = 1'b1;
                    seen_d  = 1'b0;
                end else if (timeout) begin
                    k_load = 1'b1;
                    seen_d = 1'b0;
                    if (retry_cnt == 2'(MAX_RETRY - 1)) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = RECOVER;
                        retry_d = retry_cnt + 2'd1;
                        wdr_d   = 1'b1;
                        h_load  = 1'b1;
                    end
                end else if (k_term) begin
                    k_load = 1'b1;
                    // A missed window leaves the watchdog to expire on its own.
                    if (seen_q || alive) begin
                        svc_d   = 1'b1;
                        seen_d  = 1'b0;
                        retry_d = 2'd0;
                    end
                end else begin
                    k_step = 1'b1;
                    if (alive) seen_d = 1'b1;
                end
            end
            RECOVER: begin
                k_load = 1'b1;
                if (h_term) begin
                    seen_d  = 1'b0;
                    state_d = en ? ARMED : IDLE;
                    svc_d   = en;
                end else begin
                    h_step = 1'b1;
                end
            end
            FAULT: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            service    <= 1'b0;
            wd_rst_req <= 1'b0;
            fault      <= 1'b0;
            retry_cnt  <= 2'd0;
            seen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            service    <= svc_d;
            wd_rst_req <= wdr_d;
            fault      <= fault_d;
            retry_cnt  <= retry_d;
            seen_q     <= seen_d;
        end
    end

    assign state = state_q;
endmodule

// File: tb/tb_wdt_service_ctrl.sv
// Bench for wdt_service_ctrl: directed scenarios plus random traffic against
// a deadline-based reference model.
module tb_wdt_service_ctrl;
    localparam int KI = 8, HO = 4, MR = 3;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, alive = 1'b0, timeout = 1'b0;
    logic service, wd_rst_req, fault;
    logic [1:0] state, retry_cnt;
    wire  [6:0] obs = {state, service, wd_rst_req, fault, retry_cnt};

    int checks = 0, errors = 0;

    // Model: mode 0 idle, 1 armed, 2 recovering, 3 faulted; deadlines are absolute edge numbers.
    int t = 0, m_mode, m_dl, m_rec_end, m_retry;
    bit m_alive, m_svc, m_wdr, m_fault;

    wdt_service_ctrl #(.CNT_WIDTH(5), .KICK_INTERVAL(KI), .HOLDOFF(HO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .alive(alive), .timeout(timeout),
        .service(service), .wd_rst_req(wd_rst_req), .fault(fault),
        .state(state), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = 0; m_dl = 0; m_rec_end = 0; m_retry = 0;
        m_alive = 0; m_svc = 0; m_wdr = 0; m_fault = 0;
    endfunction

    function automatic logic [6:0] model_out();
        return {2'(m_mode), m_svc, m_wdr, m_fault, 2'(m_retry)};
    endfunction

    function automatic void model_step(bit e, bit a, bit to);
        m_svc = 0; m_wdr = 0;
        if (m_mode == 0) begin
            if (e) begin m_mode = 1; m_svc = 1; m_dl = t + KI; m_alive = 0; end
        end else if (m_mode == 1) begin
            if (!e) begin
                m_mode = 0; m_alive = 0;
            end else if (to) begin
                m_alive = 0;
                if (m_retry == MR - 1) begin m_mode = 3; m_fault = 1; end
                else begin m_retry++; m_mode = 2; m_wdr = 1; m_rec_end = t + HO; end
            end else if (t == m_dl) begin
                m_dl = t + KI;
                if (m_alive || a) begin m_svc = 1; m_alive = 0; m_retry = 0; end
            end else begin
                m_alive = m_alive | a;
            end
        end else if (m_mode == 2) begin
            if (t == m_rec_end) begin
                if (e) begin m_mode = 1; m_svc = 1; m_dl = t + KI; m_alive = 0; end
                else m_mode = 0;
            end
        end
        t++;
    endfunction

    task automatic tick(input bit e, input bit a, input bit to);
        en = e; alive = a; timeout = to;
        @(posedge clk);
        model_step(e, a, to);
        @(negedge clk);
    endtask

    task automatic do_reset();
        en = 0; alive = 0; timeout = 0; rst_n = 0;
        @(negedge clk);
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        checks++;
        if (obs !== 7'd0) begin errors++; $display("FAIL reset got=%b exp=%b", obs, 7'd0); end
        do_reset();
    endtask

    task automatic test_healthy();
        int n_svc = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick(1, 1, 0);
            n_svc += int'(service);
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL healthy cyc=%0d got=%b exp=%b", i, obs, model_out()); end
        end
        checks++;
        if (n_svc != 4) begin errors++; $display("FAIL healthy_count got=%0d exp=4", n_svc); end
    endtask

    task automatic test_missed();
        int n_rec = 0;
        do_reset();
        tick(1, 1, 0);
        for (int i = 0; i < 27; i++) begin
            if (i < 20) tick(1, 0, 0);
            else if (i == 20) tick(1, 0, 1);
            else tick(1, 0, 0);
            if (i >= 20 && state == 2'd2) n_rec++;
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL missed cyc=%0d got=%b exp=%b", i, obs, model_out()); end
        end
        checks++;
        if (n_rec != HO || retry_cnt !== 2'd1) begin
            errors++; $display("FAIL missed_recover got=%0d/%0d exp=%0d/1", n_rec, retry_cnt, HO);
        end
    endtask

    task automatic test_escalation();
        int n_wdr = 0, n_pulse = 0;
        do_reset();
        tick(1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, 1);
            n_wdr += int'(wd_rst_req);
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL escal_to k=%0d got=%b exp=%b", k, obs, model_out()); end
            repeat (6) tick(1, 0, 0);
        end
        for (int i = 0; i < 50; i++) begin
            tick(1, i[0], i[2]);
            n_pulse += int'(service) + int'(wd_rst_req);
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL escal_hold cyc=%0d got=%b exp=%b", i, obs, model_out()); end
        end
        checks++;
        if (n_wdr != 2 || n_pulse != 0 || fault !== 1'b1) begin
            errors++; $display("FAIL escal_summary got=%0d/%0d/%b exp=2/0/1", n_wdr, n_pulse, fault);
        end
    endtask

    task automatic test_collision();
        do_reset();
        tick(1, 1, 0);
        repeat (7) tick(1, 0, 0);
        tick(1, 1, 1);
        checks++;
        if (obs !== model_out() || service !== 1'b0 || wd_rst_req !== 1'b1 || state !== 2'd2) begin
            errors++; $display("FAIL collision got=%b exp=%b", obs, model_out());
        end
    endtask

    task automatic test_en_drop();
        do_reset();
        repeat (3) tick(1, 1, 0);
        tick(0, 1, 0);
        checks++;
        if (obs !== model_out() || state !== 2'd0) begin errors++; $display("FAIL en_drop_armed got=%b exp=%b", obs, model_out()); end
        tick(1, 0, 0);
        tick(1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            tick(0, 1, 0);
            checks++;
            if (obs !== model_out() || service !== 1'b0) begin errors++; $display("FAIL en_drop_rec cyc=%0d got=%b exp=%b", i, obs, model_out()); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1, 0, 0);
        tick(1, 0, 1);
        tick(1, 0, 0);
        #1 rst_n = 0;
        #1;
        checks++;
        if (obs !== 7'd0) begin errors++; $display("FAIL areset_recover got=%b exp=%b", obs, 7'd0); end
        model_reset();
        rst_n = 1;
        tick(1, 0, 0);
        for (int k = 0; k < 3; k++) begin tick(1, 0, 1); repeat (5) tick(1, 0, 0); end
        checks++;
        if (obs !== model_out() || fault !== 1'b1) begin errors++; $display("FAIL areset_prefault got=%b exp=%b", obs, model_out()); end
        #1 rst_n = 0;
        #1;
        checks++;
        if (obs !== 7'd0) begin errors++; $display("FAIL areset_fault got=%b exp=%b", obs, 7'd0); end
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                #1 rst_n = 0;
                #1;
                checks++;
                if (obs !== 7'd0) begin errors++; $display("FAIL rand_reset cyc=%0d got=%b", i, obs); end
                model_reset();
                rst_n = 1;
            end
            tick($urandom_range(15) != 0, $urandom_range(3) == 0, $urandom_range(24) == 0);
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, model_out()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_healthy();
        test_missed();
        test_escalation();
        test_collision();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
